ldpc_sched: RTL and testbench

LDPC_SCHED -- requirements
Module: ldpc_sched

---
 rtl/ldpc_sched_if.sv | 46 ++++
 rtl/ldpc_sched.sv | 158 +++++++++++++++
 tb/tb_ldpc_sched.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ldpc_sched_if.sv
// Bundled source, decoder and output-side signals of the LDPC frame scheduler.
// The scheduler connects through the slave view; the bench or upstream logic uses the master view.
interface ldpc_sched_if #(
   parameter int D_WID = 6,
   parameter int CNT_W = 16
);
   logic             enable;
   logic             cfg_rate;
   logic [4:0]       cfg_max_iter;
   logic             src_vld;
   logic [D_WID-1:0] src_data;
   logic             src_rdy;
   logic [D_WID-1:0] dec_data_in;
   logic             dec_sync_in;
   logic             dec_rate;
   logic [4:0]       dec_max_iter;
   logic             dec_data_out;
   logic             dec_sync_out;
   logic             dec_busy;
   logic [4:0]       dec_num_iter;
   logic             out_data;
   logic             out_vld;
   logic             out_sof;
   logic             out_eof;
   logic             frame_done;
   logic [4:0]       last_iter;
   logic [CNT_W-1:0] frame_cnt;
   logic [CNT_W-1:0] fail_cnt;
   logic             err_gap;

   modport slave (
      input  enable, cfg_rate, cfg_max_iter, src_vld, src_data,
             dec_data_out, dec_sync_out, dec_busy, dec_num_iter,
      output src_rdy, dec_data_in, dec_sync_in, dec_rate, dec_max_iter,
             out_data, out_vld, out_sof, out_eof, frame_done, last_iter,
             frame_cnt, fail_cnt, err_gap
   );

   modport master (
      output enable, cfg_rate, cfg_max_iter, src_vld, src_data,
             dec_data_out, dec_sync_out, dec_busy, dec_num_iter,
      input  src_rdy, dec_data_in, dec_sync_in, dec_rate, dec_max_iter,
             out_data, out_vld, out_sof, out_eof, frame_done, last_iter,
             frame_cnt, fail_cnt, err_gap
   );
endinterface

// File: rtl/ldpc_sched.sv
// LDPC frame scheduler: feeds one contiguous codeword of soft samples to the decoder,
// frames the decoded bit stream and keeps per-frame statistics.
module ldpc_sched #(
   parameter int FRAME_LEN = 9216,
   parameter int D_WID     = 6,
   parameter int CNT_W     = 16
) (
   input  logic          clk,
   input  logic          rst,
   ldpc_sched_if.slave   bus
);
   localparam int SMP_W = $clog2(FRAME_LEN + 1);
   localparam logic [SMP_W-1:0] LAST_SMP = SMP_W'(FRAME_LEN);
   localparam logic [SMP_W-1:0] K_R0     = SMP_W'(FRAME_LEN / 2);
   localparam logic [SMP_W-1:0] K_R1     = SMP_W'(FRAME_LEN * 3 / 4);

   typedef enum logic [1:0] {IDLE, LOAD, DECODE, FLUSH} state_t;
   typedef struct packed {
      logic       rate;
      logic [4:0] max_iter;
   } cfg_t;

   state_t           state_q, state_d;
   cfg_t             cfg_q, cfg_d;
   logic [SMP_W-1:0] smp_cnt_q, smp_cnt_d;
   logic [SMP_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             sync_in_q, sync_in_d;
   logic [D_WID-1:0] data_in_q, data_in_d;
   logic             out_vld_q, out_vld_d;
   logic             out_data_q, out_data_d;
   logic             out_sof_q, out_sof_d;
   logic             out_eof_q, out_eof_d;
   logic             frame_done_q, frame_done_d;
   logic [4:0]       last_iter_q, last_iter_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
   logic             err_gap_q, err_gap_d;
   logic             src_rdy, accept, last_bit;
   logic [SMP_W-1:0] k_bits;

   always_comb begin
      state_d      = state_q;
      cfg_d        = cfg_q;
      smp_cnt_d    = smp_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      out_vld_d    = 1'b0;
      out_data_d   = 1'b0;
      out_sof_d    = 1'b0;
      out_eof_d    = 1'b0;
      frame_done_d = 1'b0;
      last_iter_d  = last_iter_q;
      frame_cnt_d  = frame_cnt_q;
      fail_cnt_d   = fail_cnt_q;
      err_gap_d    = err_gap_q;
      src_rdy      = 1'b0;
      k_bits       = cfg_q.rate ? K_R1 : K_R0;
      last_bit     = (bit_cnt_q + SMP_W'(1)) == k_bits;

      case (state_q)
         IDLE: begin
            src_rdy = bus.enable & ~bus.dec_busy;
            if (src_rdy && bus.src_vld) begin
               cfg_d     = '{rate: bus.cfg_rate, max_iter: bus.cfg_max_iter};
               smp_cnt_d = SMP_W'(1);
               bit_cnt_d = '0;
               state_d   = LOAD;
            end
         end
         LOAD: begin
            src_rdy = 1'b1;
            if (bus.src_vld) begin
               smp_cnt_d = smp_cnt_q + SMP_W'(1);
               if (smp_cnt_d == LAST_SMP) state_d = DECODE;
            end else begin
               // The decoder needs an unbroken frame, so a hole aborts it.
               err_gap_d = 1'b1;
               state_d   = FLUSH;
            end
         end
         DECODE: begin
            if (bus.dec_sync_out) begin
               bit_cnt_d  = bit_cnt_q + SMP_W'(1);
               out_vld_d  = 1'b1;
               out_data_d = bus.dec_data_out;
               out_sof_d  = (bit_cnt_q == '0);
               if (last_bit) begin
                  out_eof_d    = 1'b1;
                  frame_done_d = 1'b1;
                  last_iter_d  = bus.dec_num_iter;
                  frame_cnt_d  = (&frame_cnt_q) ? frame_cnt_q : frame_cnt_q + CNT_W'(1);
                  if (bus.dec_num_iter >= cfg_q.max_iter)
                     fail_cnt_d = (&fail_cnt_q) ? fail_cnt_q : fail_cnt_q + CNT_W'(1);
                  state_d = IDLE;
               end
            end
         end
         FLUSH: begin
            if (!bus.dec_busy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      accept    = src_rdy & bus.src_vld;
      sync_in_d = accept;
      data_in_d = accept ? bus.src_data : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cfg_q        <= '0;
         smp_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         sync_in_q    <= 1'b0;
         data_in_q    <= '0;
         out_vld_q    <= 1'b0;
         out_data_q   <= 1'b0;
         out_sof_q    <= 1'b0;
         out_eof_q    <= 1'b0;
         frame_done_q <= 1'b0;
         last_iter_q  <= '0;
         frame_cnt_q  <= '0;
         fail_cnt_q   <= '0;
         err_gap_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cfg_q        <= cfg_d;
         smp_cnt_q    <= smp_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         sync_in_q    <= sync_in_d;
         data_in_q    <= data_in_d;
         out_vld_q    <= out_vld_d;
         out_data_q   <= out_data_d;
         out_sof_q    <= out_sof_d;
         out_eof_q    <= out_eof_d;
         frame_done_q <= frame_done_d;
         last_iter_q  <= last_iter_d;
         frame_cnt_q  <= frame_cnt_d;
         fail_cnt_q   <= fail_cnt_d;
         err_gap_q    <= err_gap_d;
      end
   end

   assign bus.src_rdy      = src_rdy;
   assign bus.dec_data_in  = data_in_q;
   assign bus.dec_sync_in  = sync_in_q;
   assign bus.dec_rate     = cfg_q.rate;
   assign bus.dec_max_iter = cfg_q.max_iter;
   assign bus.out_data     = out_data_q;
   assign bus.out_vld      = out_vld_q;
   assign bus.out_sof      = out_sof_q;
   assign bus.out_eof      = out_eof_q;
   assign bus.frame_done   = frame_done_q;
   assign bus.last_iter    = last_iter_q;
   assign bus.frame_cnt    = frame_cnt_q;
   assign bus.fail_cnt     = fail_cnt_q;
   assign bus.err_gap      = err_gap_q;
endmodule

// File: tb/tb_ldpc_sched.sv
// Directed bench for ldpc_sched: stimulus pushes expected decoder-input samples and output
// bits (with the cycle they must appear) into queues; negedge monitors pop and compare.
module tb_ldpc_sched;
   localparam int FL = 9216;
   localparam int DW = 6;
   localparam int CW = 16;

   typedef struct {logic [DW-1:0] d; int cyc;} in_t;
   typedef struct {logic d; bit sof; bit eof; int cyc;} out_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   in_t  in_q[$];
   out_t out_q[$];

   ldpc_sched_if #(.D_WID(DW), .CNT_W(CW)) bus ();
   ldpc_sched #(.FRAME_LEN(FL), .D_WID(DW), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      logic exp_sync;
      exp_sync = (in_q.size() != 0) && (in_q[0].cyc == cyc);
      chk("dec_sync_in", bus.dec_sync_in === exp_sync, bus.dec_sync_in, exp_sync);
      if (exp_sync) begin
         in_t e;
         e = in_q.pop_front();
         chk("dec_data_in", bus.dec_data_in === e.d, bus.dec_data_in, e.d);
      end else begin
         chk("dec_data_in_idle", bus.dec_data_in === {DW{1'b0}}, bus.dec_data_in, 0);
      end
   end

   always @(negedge clk) begin
      logic exp_vld;
      exp_vld = (out_q.size() != 0) && (out_q[0].cyc == cyc);
      chk("out_vld", bus.out_vld === exp_vld, bus.out_vld, exp_vld);
      if (exp_vld) begin
         out_t e;
         e = out_q.pop_front();
         chk("out_data", bus.out_data === e.d, bus.out_data, e.d);
         chk("out_sof", bus.out_sof === e.sof, bus.out_sof, e.sof);
         chk("out_eof", bus.out_eof === e.eof, bus.out_eof, e.eof);
         chk("frame_done", bus.frame_done === e.eof, bus.frame_done, e.eof);
      end else begin
         chk("out_idle", {bus.out_data, bus.out_sof, bus.out_eof, bus.frame_done} === 4'b0000,
             {bus.out_data, bus.out_sof, bus.out_eof, bus.frame_done}, 0);
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int n, input int tog_at, input int enoff_at);
      for (int i = 0; i < n; i++) begin
         if (i == tog_at) bus.cfg_rate = ~bus.cfg_rate;
         if (i == enoff_at) bus.enable = 1'b0;
         bus.src_vld  = 1'b1;
         bus.src_data = DW'($urandom);
         in_q.push_back('{d: bus.src_data, cyc: cyc + 1});
         tick();
      end
      bus.src_vld = 1'b0;
   endtask

   task automatic decode(input int nb, input int k);
      for (int j = 0; j < nb; j++) begin
         if (j % 7 == 3) begin
            bus.dec_sync_out = 1'b0;
            bus.dec_data_out = 1'($urandom);
            tick();
         end
         bus.dec_sync_out = 1'b1;
         bus.dec_data_out = 1'($urandom);
         out_q.push_back('{d: bus.dec_data_out, sof: (j == 0), eof: (j == k - 1), cyc: cyc + 1});
         tick();
      end
      bus.dec_sync_out = 1'b0;
   endtask

   task automatic noise(input int n);
      for (int j = 0; j < n; j++) begin
         bus.dec_sync_out = 1'b1;
         bus.dec_data_out = 1'b1;
         tick();
      end
      bus.dec_sync_out = 1'b0;
   endtask

   initial begin
      bus.enable = 1'b0; bus.cfg_rate = 1'b0; bus.cfg_max_iter = 5'd0;
      bus.src_vld = 1'b0; bus.src_data = '0;
      bus.dec_data_out = 1'b0; bus.dec_sync_out = 1'b0;
      bus.dec_busy = 1'b0; bus.dec_num_iter = 5'd0;

      tick(); tick();
      chk("rst_src_rdy", bus.src_rdy === 1'b0, bus.src_rdy, 0);
      chk("rst_frame_cnt", bus.frame_cnt === 16'd0, bus.frame_cnt, 0);
      chk("rst_fail_cnt", bus.fail_cnt === 16'd0, bus.fail_cnt, 0);
      chk("rst_err_gap", bus.err_gap === 1'b0, bus.err_gap, 0);
      chk("rst_cfg", {bus.dec_rate, bus.dec_max_iter} === 6'd0, {bus.dec_rate, bus.dec_max_iter}, 0);
      chk("rst_last_iter", bus.last_iter === 5'd0, bus.last_iter, 0);
      rst = 1'b0;
      tick();

      bus.enable = 1'b1; bus.dec_busy = 1'b1;
      bus.src_vld = 1'b1; bus.src_data = 6'h2a;
      for (int i = 0; i < 3; i++) begin
         chk("busy_src_rdy", bus.src_rdy === 1'b0, bus.src_rdy, 0);
         tick();
      end
      bus.dec_busy = 1'b0;
      #1;
      chk("unbusy_src_rdy", bus.src_rdy === 1'b1, bus.src_rdy, 1);

      bus.cfg_rate = 1'b0; bus.cfg_max_iter = 5'd20;
      load(FL, 50, -1);
      chk("A_dec_rate", bus.dec_rate === 1'b0, bus.dec_rate, 0);
      chk("A_dec_max_iter", bus.dec_max_iter === 5'd20, bus.dec_max_iter, 20);
      bus.dec_busy = 1'b1;
      bus.src_vld = 1'b1;
      chk("A_decode_src_rdy", bus.src_rdy === 1'b0, bus.src_rdy, 0);
      tick(); tick();
      bus.src_vld = 1'b0;
      bus.dec_num_iter = 5'd7;
      decode(FL / 2, FL / 2);
      chk("A_frame_cnt", bus.frame_cnt === 16'd1, bus.frame_cnt, 1);
      chk("A_fail_cnt", bus.fail_cnt === 16'd0, bus.fail_cnt, 0);
      chk("A_last_iter", bus.last_iter === 5'd7, bus.last_iter, 7);
      bus.dec_busy = 1'b0;
      bus.enable = 1'b0;
      noise(3);
      chk("dis_src_rdy", bus.src_rdy === 1'b0, bus.src_rdy, 0);

      bus.enable = 1'b1; bus.cfg_rate = 1'b1; bus.cfg_max_iter = 5'd5;
      load(FL, -1, 200);
      chk("B_dec_rate", bus.dec_rate === 1'b1, bus.dec_rate, 1);
      chk("B_dec_max_iter", bus.dec_max_iter === 5'd5, bus.dec_max_iter, 5);
      bus.enable = 1'b1; bus.dec_busy = 1'b1; bus.dec_num_iter = 5'd5;
      decode(FL * 3 / 4, FL * 3 / 4);
      chk("B_frame_cnt", bus.frame_cnt === 16'd2, bus.frame_cnt, 2);
      chk("B_fail_cnt", bus.fail_cnt === 16'd1, bus.fail_cnt, 1);
      chk("B_last_iter", bus.last_iter === 5'd5, bus.last_iter, 5);
      bus.dec_busy = 1'b0;
      tick();

      bus.cfg_rate = 1'b0; bus.cfg_max_iter = 5'd9;
      load(99, -1, -1);
      bus.dec_busy = 1'b1;
      tick();
      chk("gap_err_gap", bus.err_gap === 1'b1, bus.err_gap, 1);
      bus.src_vld = 1'b1;
      chk("flush_src_rdy", bus.src_rdy === 1'b0, bus.src_rdy, 0);
      noise(4);
      bus.src_vld = 1'b0;
      chk("flush_hold_src_rdy", bus.src_rdy === 1'b0, bus.src_rdy, 0);
      bus.dec_busy = 1'b0;
      tick();
      chk("flush_exit_src_rdy", bus.src_rdy === 1'b1, bus.src_rdy, 1);
      chk("gap_frame_cnt", bus.frame_cnt === 16'd2, bus.frame_cnt, 2);
      chk("gap_fail_cnt", bus.fail_cnt === 16'd1, bus.fail_cnt, 1);
      chk("gap_sticky", bus.err_gap === 1'b1, bus.err_gap, 1);

      bus.cfg_rate = 1'b0; bus.cfg_max_iter = 5'd20;
      load(FL, -1, -1);
      bus.dec_busy = 1'b1; bus.dec_num_iter = 5'd4;
      decode(100, FL / 2);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_outs", {bus.out_vld, bus.out_sof, bus.out_eof, bus.frame_done, bus.dec_sync_in} === 5'd0,
          {bus.out_vld, bus.out_sof, bus.out_eof, bus.frame_done, bus.dec_sync_in}, 0);
      chk("mid_rst_frame_cnt", bus.frame_cnt === 16'd0, bus.frame_cnt, 0);
      chk("mid_rst_fail_cnt", bus.fail_cnt === 16'd0, bus.fail_cnt, 0);
      chk("mid_rst_err_gap", bus.err_gap === 1'b0, bus.err_gap, 0);
      chk("mid_rst_cfg", {bus.dec_rate, bus.dec_max_iter} === 6'd0, {bus.dec_rate, bus.dec_max_iter}, 0);
      chk("mid_rst_last_iter", bus.last_iter === 5'd0, bus.last_iter, 0);
      tick(); tick();
      rst = 1'b0;
      noise(3);
      chk("post_rst_busy_src_rdy", bus.src_rdy === 1'b0, bus.src_rdy, 0);
      bus.dec_busy = 1'b0;
      #1;
      chk("post_rst_src_rdy", bus.src_rdy === 1'b1, bus.src_rdy, 1);

      bus.cfg_max_iter = 5'd3;
      load(FL, -1, -1);
      bus.dec_busy = 1'b1; bus.dec_num_iter = 5'd3;
      decode(FL / 2, FL / 2);
      chk("C_frame_cnt", bus.frame_cnt === 16'd1, bus.frame_cnt, 1);
      chk("C_fail_cnt", bus.fail_cnt === 16'd1, bus.fail_cnt, 1);
      chk("C_last_iter", bus.last_iter === 5'd3, bus.last_iter, 3);
      chk("C_dec_max_iter", bus.dec_max_iter === 5'd3, bus.dec_max_iter, 3);
      bus.dec_busy = 1'b0;
      tick(); tick(); tick();
      chk("in_q_drained", in_q.size() === 0, in_q.size(), 0);
      chk("out_q_drained", out_q.size() === 0, out_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
